tdc_coarse_multi: RTL and testbench
===================================

Name: tdc_coarse_multi

Overview:
Multi-channel coarse counter for the TDC. One shared start event and CHANNELS independent stop events are synchronised into the clk domain. Each channel's elapsed clk-cycle count is measured against the common start. Results are presented as one measurement record over a valid/ready handshake. The fine (delay-line) stage and the readout logic sit downstream and consume the record.

Parameters:
CHANNELS, 4, number of independent stop channels (1..16)
WIDTH, 11, counter and per-channel result width in bits
SYNC_STAGES, 2, flip-flops in each event synchroniser (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
arm  input  1  one-cycle request to arm a new measurement
start_evt  input  1  asynchronous start event; rising edge is significant
stop_evt  input  CHANNELS  asynchronous per-channel stop events; rising edge is significant
busy  output  1  high whenever state is not IDLE
meas_valid  output  1  measurement record available
meas_ready  input  1  downstream accepts the record
count  output  CHANNELS*WIDTH  per-channel result; channel i occupies bits [i*WIDTH +: WIDTH]
overflow  output  CHANNELS  per-channel flag: no stop was seen before saturation

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; counter, synchronisers and stopped mask are cleared.
  - count, overflow, meas_valid and busy are all 0.
  - Applies immediately, including mid-measurement; any partial measurement is discarded.
- Synchronisers: each event passes through SYNC_STAGES flops, then a rising-edge detector.
  - Detection occurs SYNC_STAGES+1 clk edges after an input edge that is synchronous to clk.
  - Start and stop paths share this latency, so it cancels in the result.
- FSM states: IDLE, ARMED, COUNT, DONE.
- IDLE:
  - arm=1 moves to ARMED.
  - Events are ignored.
- ARMED:
  - Detected start edge moves to COUNT: counter clears to 0, stopped mask clears, and count/overflow clear to 0.
  - Stop edges are ignored, including one detected in the same cycle as start.
- COUNT:
  - Counter increments by 1 every cycle.
  - Result definition: a stop detected k clk edges after start detection records count[i]=k (k>=1).
  - Only the first stop per channel is recorded; later edges on a stopped channel are ignored.
  - Several channels stopping in the same cycle each record the same k.
  - Transition to DONE occurs on the cycle the last unstopped channel records.
- Saturation:
  - If the value to be recorded reaches 2^WIDTH-1 while channels remain unstopped, those channels record 2^WIDTH-1 with overflow[i]=1, and the state moves to DONE.
  - A stop detected in exactly that cycle wins: it records 2^WIDTH-1 with overflow[i]=0.
  - Counter never wraps.
- DONE:
  - meas_valid=1; count and overflow are held stable.
  - When meas_valid & meas_ready, the state moves to IDLE and meas_valid is 0 on the next cycle.
  - meas_ready may be held high permanently, giving a 1-cycle DONE.
- Holding and ignored inputs:
  - After DONE, count and overflow hold their values until the next start detect in ARMED.
  - arm is ignored in every state other than IDLE.
  - Event edges outside ARMED/COUNT are ignored.
- busy = (state != IDLE); it is registered, with no combinational path from inputs.

Test Plan:
- Single measurement: CHANNELS=4, WIDTH=11. arm; start edge at cycle 0; stops at cycles 10, 20, 30, 40 (all clk-synchronous) -> count = 10, 20, 30, 40; overflow = 0000; meas_valid rises 1 cycle after the last stop is detected.
- Simultaneous stops: stops on channels 0 and 2 both at cycle 5, channels 1 and 3 at cycle 7 -> count = 5, 7, 5, 7; one DONE entry.
- Saturation: WIDTH=4; channel 0 stops at cycle 3, others never stop -> count0 = 3, channels 1-3 = 15, overflow = 1110. A stop on channel 1 exactly at k=15 instead -> count1 = 15, overflow1 = 0.
- Handshake/backpressure: hold meas_ready=0 for 20 cycles in DONE -> meas_valid and count stable throughout; a new arm is ignored; a meas_ready pulse -> IDLE, and the next arm/start runs normally.
- Ignored events: stop edges in IDLE/ARMED, a second stop on an already-stopped channel, and a start edge during COUNT -> no change to recorded values.
- Reset mid-COUNT: assert reset at k=6 -> all outputs 0 asynchronously; after release, a fresh arm/start with stop at 9 -> count = 9.

Source files
------------

// File: rtl/tdc_coarse_multi.sv
// -----------------------------------------------------------------------------
// tdc_coarse_multi
//
// Coarse (clk-cycle) stage of a multi-channel time-to-digital converter.
// A shared start event and CHANNELS stop events are synchronised into the clk
// domain and edge-detected. After arming, a start edge launches a counter. Each
// channel records the count at which its first stop edge is seen. When every
// channel has recorded, or the counter saturates, the record is offered
// downstream over a valid/ready handshake.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   arm         one-cycle request to arm a new measurement (honoured in IDLE only)
//   start_evt   asynchronous start event, rising edge significant
//   stop_evt    asynchronous per-channel stop events, rising edge significant
//   busy        high whenever the FSM is not IDLE
//   meas_valid  measurement record available (state DONE)
//   meas_ready  downstream accepts the record
//   count       per-channel result, channel i at [i*WIDTH +: WIDTH]
//   overflow    per-channel flag: counter saturated before a stop was seen
//   dbg_state   current FSM state (0 IDLE, 1 ARMED, 2 COUNT, 3 DONE)
//
// Handshake: meas_valid is high for as long as the FSM sits in DONE; the record
// (count/overflow) is stable while meas_valid is high. A transfer happens on a
// clk edge where meas_valid & meas_ready are both high; meas_valid is low from
// the following cycle. meas_ready may be tied high (one-cycle DONE).
// -----------------------------------------------------------------------------
module tdc_coarse_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      start_evt,
  input  logic [CHANNELS-1:0]       stop_evt,
  output logic                      busy,
  output logic                      meas_valid,
  input  logic                      meas_ready,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       overflow,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int               EW      = CHANNELS + 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------------
  // Event synchronisers. Bit 0 carries start, bits [CHANNELS:1] carry stops, so
  // every event sees exactly the same latency and it cancels in the result.
  // ---------------------------------------------------------------------------
  logic [EW-1:0]       sync_q [SYNC_STAGES];
  logic [EW-1:0]       evt_prev;
  logic [EW-1:0]       evt_rise;
  logic                start_det;
  logic [CHANNELS-1:0] stop_det;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      evt_prev <= '0;
    end else begin
      sync_q[0] <= {stop_evt, start_evt};
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      evt_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_rise  = sync_q[SYNC_STAGES-1] & ~evt_prev;
  assign start_det = evt_rise[0];
  assign stop_det  = evt_rise[EW-1:1];

  // ---------------------------------------------------------------------------
  // Counter and per-channel capture.
  // cnt holds the number of COUNT edges already taken; the value recorded on a
  // given edge is therefore cnt+1, which makes a stop detected k edges after
  // the start record exactly k.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    cnt_inc;
  logic [CHANNELS-1:0] stopped;
  logic [CHANNELS-1:0] stop_new;
  logic                sat;
  logic                all_stopped;

  assign cnt_inc     = cnt + 1'b1;
  assign stop_new    = stop_det & ~stopped;
  assign sat         = (cnt_inc == CNT_MAX);
  // Channels stopping this cycle count as done, so DONE is entered on the same
  // edge the last channel records.
  assign all_stopped = &(stopped | stop_det);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      stopped  <= '0;
      count    <= '0;
      overflow <= '0;
    end else if (state == ARMED && start_det) begin
      cnt      <= '0;
      stopped  <= '0;
      count    <= '0;
      overflow <= '0;
    end else if (state == COUNT) begin
      // On the saturating edge the FSM leaves COUNT, so cnt never wraps.
      cnt <= cnt_inc;
      for (int i = 0; i < CHANNELS; i++) begin
        if (stop_new[i]) begin
          // A stop on the saturating edge still wins: value MAX, no overflow.
          count[i*WIDTH +: WIDTH] <= cnt_inc;
          stopped[i]              <= 1'b1;
        end else if (sat && !stopped[i]) begin
          count[i*WIDTH +: WIDTH] <= CNT_MAX;
          overflow[i]             <= 1'b1;
          stopped[i]              <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm)                    state_nxt = ARMED;
      ARMED:   if (start_det)              state_nxt = COUNT;
      COUNT:   if (all_stopped || sat)     state_nxt = DONE;
      DONE:    if (meas_ready)             state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Both are decodes of the state register only: no input-to-output path.
  assign busy       = (state != IDLE);
  assign meas_valid = (state == DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_tdc_coarse_multi.sv
// -----------------------------------------------------------------------------
// tb_tdc_coarse_multi
//
// Two instances share reset, start and stop lines: dut_a (WIDTH=11) and dut_b
// (WIDTH=4, reaches saturation quickly). Each measurement is described as a
// schedule of event pulse times relative to the start pulse; the expected
// record is derived from those times alone (first stop after start, clipped to
// the saturation value). The idle instance must ignore all shared events.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tdc_coarse_multi;

  localparam int CH   = 4;
  localparam int WA   = 11;
  localparam int WB   = 4;
  localparam int SS   = 2;
  localparam int NONE = -1000;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            arm_a, arm_b, ready_a, ready_b, start_evt;
  logic [CH-1:0]   stop_evt;
  logic            busy_a, busy_b, valid_a, valid_b;
  logic [CH*WA-1:0] count_a;
  logic [CH*WB-1:0] count_b;
  logic [CH-1:0]   ov_a, ov_b;
  logic [1:0]      dbg_a, dbg_b;

  tdc_coarse_multi #(.CHANNELS(CH), .WIDTH(WA), .SYNC_STAGES(SS)) dut_a (
    .clk(clk), .reset(reset), .arm(arm_a), .start_evt(start_evt),
    .stop_evt(stop_evt), .busy(busy_a), .meas_valid(valid_a),
    .meas_ready(ready_a), .count(count_a), .overflow(ov_a), .dbg_state(dbg_a)
  );

  tdc_coarse_multi #(.CHANNELS(CH), .WIDTH(WB), .SYNC_STAGES(SS)) dut_b (
    .clk(clk), .reset(reset), .arm(arm_b), .start_evt(start_evt),
    .stop_evt(stop_evt), .busy(busy_b), .meas_valid(valid_b),
    .meas_ready(ready_b), .count(count_b), .overflow(ov_b), .dbg_state(dbg_b)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  // schedule of the current measurement (times relative to start pulse)
  int stop1 [CH];
  int stop2 [CH];
  int xstart;
  int arm_extra;
  int ready_t;
  bit rdy_hold;
  int cur_d;

  // expected record
  int exp_q [$];
  bit exp_ov [CH];
  int exp_lat;
  int last_cnt [2][CH];
  bit last_ov  [2][CH];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int get_cnt(input int d, input int ch);
    if (d == 0) return int'(count_a[ch*WA +: WA]);
    return int'(count_b[ch*WB +: WB]);
  endfunction

  function automatic int get_ov(input int d, input int ch);
    if (d == 0) return int'(ov_a[ch]);
    return int'(ov_b[ch]);
  endfunction

  function automatic int get_valid(input int d);
    return (d == 0) ? int'(valid_a) : int'(valid_b);
  endfunction

  function automatic int get_busy(input int d);
    return (d == 0) ? int'(busy_a) : int'(busy_b);
  endfunction

  // Reference model: first stop pulse at k>=1 after start gives k; none up to
  // the saturation value gives the saturation value with overflow. DONE is
  // reached at the largest recorded k, SS+1 cycles of detection latency later.
  task automatic compute_expected(input int d);
    int mx;
    int k;
    int kmax;
    mx   = (d == 0) ? (1 << WA) - 1 : (1 << WB) - 1;
    kmax = 0;
    exp_q.delete();
    for (int ch = 0; ch < CH; ch++) begin
      k = 1 << 30;
      if (stop1[ch] >= 1) k = stop1[ch];
      if (stop2[ch] >= 1 && stop2[ch] < k) k = stop2[ch];
      if (k <= mx) begin
        exp_q.push_back(k);
        exp_ov[ch] = 1'b0;
      end else begin
        exp_q.push_back(mx);
        exp_ov[ch] = 1'b1;
        k = mx;
      end
      if (k > kmax) kmax = k;
    end
    exp_lat = kmax + SS + 1;
  endtask

  task automatic check_record(input int d, input string tag);
    for (int ch = 0; ch < CH; ch++) begin
      check_eq({tag, "_cnt"}, get_cnt(d, ch), exp_q[ch]);
      check_eq({tag, "_ov"},  get_ov(d, ch),  int'(exp_ov[ch]));
    end
  endtask

  task automatic check_last(input int d, input string tag);
    for (int ch = 0; ch < CH; ch++) begin
      check_eq({tag, "_cnt"}, get_cnt(d, ch), last_cnt[d][ch]);
      check_eq({tag, "_ov"},  get_ov(d, ch),  int'(last_ov[d][ch]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq({tag, "_valid"}, get_valid(d), 0);
      check_eq({tag, "_busy"},  get_busy(d),  0);
      for (int ch = 0; ch < CH; ch++) begin
        check_eq({tag, "_cnt"}, get_cnt(d, ch), 0);
        check_eq({tag, "_ov"},  get_ov(d, ch),  0);
      end
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic clear_inputs();
    arm_a = 1'b0; arm_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    start_evt = 1'b0; stop_evt = '0;
  endtask

  task automatic set_none();
    for (int ch = 0; ch < CH; ch++) begin
      stop1[ch] = NONE;
      stop2[ch] = NONE;
    end
    xstart    = NONE;
    arm_extra = NONE;
    ready_t   = NONE;
    rdy_hold  = 1'b0;
  endtask

  task automatic drive_sched(input int t);
    arm_a     = (cur_d == 0) && (t == -4 || t == arm_extra);
    arm_b     = (cur_d == 1) && (t == -4 || t == arm_extra);
    ready_a   = (cur_d == 0) && (rdy_hold || t == ready_t);
    ready_b   = (cur_d == 1) && (rdy_hold || t == ready_t);
    start_evt = (t == 0) || (t == xstart);
    for (int ch = 0; ch < CH; ch++) begin
      stop_evt[ch] = (t == stop1[ch]) || (t == stop2[ch]);
    end
  endtask

  // One complete measurement on instance d. Inputs are driven and outputs
  // sampled on the falling edge. bp = cycles meas_ready is withheld in DONE.
  task automatic run_meas(input int d, input bit ready_hold, input int bp);
    int t;
    int seen;
    int rel_t;
    int t_end;
    bit timed_out;
    compute_expected(d);
    cur_d     = d;
    rdy_hold  = ready_hold;
    arm_extra = NONE;
    ready_t   = NONE;
    seen      = NONE;
    rel_t     = NONE;
    timed_out = 1'b0;
    t_end     = (xstart > 0) ? xstart : 0;
    for (int ch = 0; ch < CH; ch++) begin
      if (stop1[ch] > t_end) t_end = stop1[ch];
      if (stop2[ch] > t_end) t_end = stop2[ch];
    end
    t = -6;
    while (t < 4000) begin
      @(negedge clk);
      if (t == -5) check_eq("busy_idle", get_busy(d), 0);
      if (t == -3) check_eq("busy_armed", get_busy(d), 1);
      if (seen == NONE) begin
        if (get_valid(d) == 1) begin
          seen = t;
          check_eq("done_latency", seen, exp_lat);
          check_eq("busy_done", get_busy(d), 1);
          check_record(d, "record");
          rel_t = ready_hold ? t : t + bp;
          if (!ready_hold) begin
            arm_extra = t + 2;
            ready_t   = rel_t;
          end
        end else if (t > exp_lat + 10) begin
          check_eq("valid_timeout", 0, 1);
          timed_out = 1'b1;
          break;
        end
      end else if (t <= rel_t) begin
        check_eq("bp_valid", get_valid(d), 1);
        check_record(d, "bp_hold");
      end else if (t == rel_t + 1) begin
        check_eq("post_valid", get_valid(d), 0);
        check_eq("post_busy",  get_busy(d),  0);
        check_record(d, "post_hold");
      end
      if (seen != NONE && t > rel_t + 1 && t > t_end) break;
      drive_sched(t);
      t++;
    end
    clear_inputs();
    if (!timed_out) begin
      @(negedge clk);
      check_eq("idle_busy", get_busy(d), 0);
      check_record(d, "idle_hold");
      for (int ch = 0; ch < CH; ch++) begin
        last_cnt[d][ch] = exp_q[ch];
        last_ov[d][ch]  = exp_ov[ch];
      end
    end
    check_eq("other_busy", get_busy(1 - d), 0);
    check_last(1 - d, "other_hold");
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b0;
    clear_inputs();
    set_none();
    cur_d = 0;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < CH; ch++) begin
        last_cnt[d][ch] = 0;
        last_ov[d][ch]  = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single measurement with 20-cycle backpressure and an ignored arm
    set_none(); stop1 = '{10, 20, 30, 40};
    run_meas(0, 1'b0, 20);

    // simultaneous stops, ready held high (one-cycle DONE)
    set_none(); stop1 = '{5, 7, 5, 7};
    run_meas(0, 1'b1, 0);

    // saturation on the 4-bit instance
    set_none(); stop1[0] = 3;
    run_meas(1, 1'b0, 5);

    // stop exactly on the saturating value wins
    set_none(); stop1[0] = 3; stop1[1] = 15;
    run_meas(1, 1'b1, 0);

    // ignored events: stops in IDLE/ARMED, with start, repeated stop, start in COUNT
    set_none();
    stop1 = '{-6, 4, -2, 0};
    stop2 = '{8, 9, 11, 6};
    xstart = 6;
    run_meas(0, 1'b0, 4);

    // reset in the middle of COUNT (k=6)
    set_none(); stop1 = '{20, 20, 20, 20};
    cur_d = 0;
    for (int t = -6; t <= 9; t++) begin
      @(negedge clk);
      drive_sched(t);
    end
    #2 reset = 1'b0;
    #1;
    check_zero("mid_reset");
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < CH; ch++) begin
        last_cnt[d][ch] = 0;
        last_ov[d][ch]  = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    set_none(); stop1 = '{9, 12, 3, 20};
    run_meas(0, 1'b0, 4);

    // randomized measurements alternating between instances
    for (int n = 0; n < 16; n++) begin
      int d;
      d = n % 2;
      set_none();
      for (int ch = 0; ch < CH; ch++) begin
        if (d == 0) begin
          if ($urandom_range(0, 3) == 0) begin
            stop1[ch] = -int'($urandom_range(0, 5));
            stop2[ch] = int'($urandom_range(2, 60));
          end else begin
            stop1[ch] = int'($urandom_range(1, 60));
            if ($urandom_range(0, 1) == 1) stop2[ch] = stop1[ch] + int'($urandom_range(2, 20));
          end
        end else begin
          if ($urandom_range(0, 2) != 0) begin
            stop1[ch] = int'($urandom_range(1, 22));
            if ($urandom_range(0, 1) == 1) stop2[ch] = stop1[ch] + int'($urandom_range(2, 10));
          end
        end
      end
      if ($urandom_range(0, 1) == 1) xstart = int'($urandom_range(2, 30));
      run_meas(d, 1'($urandom_range(0, 1)), int'($urandom_range(3, 12)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
